// File: rtl/ex_mem_skid_reg_pkg.sv
// rtl/ex_mem_skid_reg_pkg.sv - shared EX/MEM bundle type and constants
package ex_mem_skid_reg_pkg;

    localparam int EX_DATA_W = 16;
    localparam int EX_RD_W   = 4;

    typedef struct packed {
        logic [EX_DATA_W-1:0] result;
        logic                 altb;
        logic [EX_RD_W-1:0]   rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic [EX_DATA_W-1:0] store_data;
    } ex_mem_bundle_t;

    localparam int BUNDLE_W = $bits(ex_mem_bundle_t);

    // r0 is hardwired to zero, so writes to it are never forwarded
    localparam logic [EX_RD_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// rtl/ex_mem_skid_reg_if.sv - EX/MEM handshake, forwarding and status signals
interface ex_mem_skid_reg_if
    import ex_mem_skid_reg_pkg::*;
#(
    parameter int DATA_W      = EX_DATA_W,
    parameter int RD_W        = EX_RD_W,
    parameter int STALL_CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_altb;
    logic [RD_W-1:0]   in_rd;
    logic              in_reg_write;
    logic              in_mem_read;
    logic              in_mem_write;
    logic [DATA_W-1:0] in_store_data;
    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_altb;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic [DATA_W-1:0] out_store_data;

    logic              fwd_valid;
    logic [RD_W-1:0]   fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    logic [1:0]             occupancy;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport slave (
        input  in_valid, in_result, in_altb, in_rd, in_reg_write,
               in_mem_read, in_mem_write, in_store_data, flush, out_ready,
        output in_ready, out_valid, out_result, out_altb, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_store_data,
               fwd_valid, fwd_rd, fwd_data, occupancy, stall_cycles
    );

    modport master (
        output in_valid, in_result, in_altb, in_rd, in_reg_write,
               in_mem_read, in_mem_write, in_store_data, flush, out_ready,
        input  in_ready, out_valid, out_result, out_altb, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_store_data,
               fwd_valid, fwd_rd, fwd_data, occupancy, stall_cycles
    );

endinterface

// File: rtl/ex_mem_entry.sv
// rtl/ex_mem_entry.sv - one EX/MEM bundle register with valid bit
module ex_mem_entry
    import ex_mem_skid_reg_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           clr,
    input  ex_mem_bundle_t d,
    output logic           valid,
    output ex_mem_bundle_t q
);
    logic           valid_d, valid_q;
    ex_mem_bundle_t data_d, data_q;

    // clear wins over load so a flush also discards a same-cycle capture
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - 2-entry EX/MEM skid register with forwarding tap
module ex_mem_skid_reg
    import ex_mem_skid_reg_pkg::*;
#(
    parameter int DATA_W      = EX_DATA_W,
    parameter int RD_W        = EX_RD_W,
    parameter int STALL_CNT_W = 16
)(
    input  logic            CLK,
    input  logic            Reset,
    ex_mem_skid_reg_if.slave bus
);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    logic                   in_ready_d, in_ready_q;
    logic [STALL_CNT_W-1:0] stall_d, stall_q;

    logic           h_valid, s_valid;
    ex_mem_bundle_t h_q, s_q, in_bundle, h_in;
    logic           push, pop;
    logic           h_load, h_clr, s_load, s_clr;

    always_comb begin
        in_bundle.result     = bus.in_result;
        in_bundle.altb       = bus.in_altb;
        in_bundle.rd         = bus.in_rd;
        in_bundle.reg_write  = bus.in_reg_write;
        in_bundle.mem_read   = bus.in_mem_read;
        in_bundle.mem_write  = bus.in_mem_write;
        in_bundle.store_data = bus.in_store_data;
    end

    assign push = bus.in_valid & in_ready_q;
    assign pop  = h_valid & bus.out_ready;

    // in_ready low means S is full, so push and a valid S never coincide
    always_comb begin
        h_in       = s_valid ? s_q : in_bundle;
        h_load     = (push & (~h_valid | pop)) | (pop & s_valid);
        h_clr      = bus.flush | (pop & ~push & ~s_valid);
        s_load     = push & h_valid & ~pop;
        s_clr      = bus.flush | (pop & s_valid);
        in_ready_d = bus.flush | ~(s_load | (s_valid & ~pop));
        stall_d    = stall_q;
        if (h_valid && !bus.out_ready && stall_q != STALL_MAX) begin
            stall_d = stall_q + 1'b1;
        end
    end

    ex_mem_entry u_head (
        .clk   (CLK),
        .rst   (Reset),
        .load  (h_load),
        .clr   (h_clr),
        .d     (h_in),
        .valid (h_valid),
        .q     (h_q)
    );

    ex_mem_entry u_skid (
        .clk   (CLK),
        .rst   (Reset),
        .load  (s_load),
        .clr   (s_clr),
        .d     (in_bundle),
        .valid (s_valid),
        .q     (s_q)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        bus.in_ready       = in_ready_q;
        bus.out_valid      = h_valid;
        bus.out_result     = h_q.result;
        bus.out_altb       = h_q.altb;
        bus.out_rd         = h_q.rd;
        bus.out_reg_write  = h_q.reg_write;
        bus.out_mem_read   = h_q.mem_read;
        bus.out_mem_write  = h_q.mem_write;
        bus.out_store_data = h_q.store_data;
        bus.fwd_valid      = h_valid & h_q.reg_write & (h_q.rd != REG_ZERO);
        bus.fwd_rd         = RD_W'(h_q.rd);
        bus.fwd_data       = DATA_W'(h_q.result);
        bus.occupancy      = {1'b0, h_valid} + {1'b0, s_valid};
        bus.stall_cycles   = stall_q;
    end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb/tb_ex_mem_skid_reg.sv - directed self-checking bench for ex_mem_skid_reg
module tb_ex_mem_skid_reg;

    logic CLK;
    logic Reset;
    int   checks;
    int   errors;

    ex_mem_skid_reg_if #(.STALL_CNT_W(2)) bus ();

    ex_mem_skid_reg #(.STALL_CNT_W(2)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [15:0] res, input logic [3:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic altb, input logic [15:0] sd);
        bus.in_valid      = 1'b1;
        bus.in_result     = res;
        bus.in_rd         = rd;
        bus.in_reg_write  = rw;
        bus.in_mem_read   = mr;
        bus.in_mem_write  = mw;
        bus.in_altb       = altb;
        bus.in_store_data = sd;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        push(16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        bus.in_valid = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_occ", bus.occupancy, 0);
        chk("rst_stall", bus.stall_cycles, 0);
        chk("rst_fwd_valid", bus.fwd_valid, 0);

        // single push with MEM ready
        bus.out_ready = 1'b1;
        push(16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        idle();
        chk("p1_out_valid", bus.out_valid, 1);
        chk("p1_out_result", bus.out_result, 32'h1234);
        chk("p1_fwd_valid", bus.fwd_valid, 1);
        chk("p1_fwd_rd", bus.fwd_rd, 3);
        chk("p1_fwd_data", bus.fwd_data, 32'h1234);
        chk("p1_occ", bus.occupancy, 1);
        step();
        chk("p1_drain_occ", bus.occupancy, 0);

        // fill to FULL under stall, then drain
        bus.out_ready = 1'b0;
        push(16'h0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        chk("f_occ1", bus.occupancy, 1);
        chk("f_in_ready1", bus.in_ready, 1);
        chk("f_stall0", bus.stall_cycles, 0);
        push(16'h0002, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA5A5);
        step();
        idle();
        chk("f_occ2", bus.occupancy, 2);
        chk("f_in_ready2", bus.in_ready, 0);
        chk("f_head_held", bus.out_result, 32'h0001);
        bus.out_ready = 1'b1;
        step();
        chk("f_pop1_result", bus.out_result, 32'h0002);
        chk("f_pop1_altb", bus.out_altb, 1);
        chk("f_pop1_mw", bus.out_mem_write, 1);
        chk("f_pop1_sd", bus.out_store_data, 32'hA5A5);
        chk("f_pop1_in_ready", bus.in_ready, 1);
        chk("f_pop1_occ", bus.occupancy, 1);
        step();
        chk("f_pop2_valid", bus.out_valid, 0);
        chk("f_stall1", bus.stall_cycles, 1);

        // back-to-back streaming
        for (int i = 0; i < 8; i++) begin
            push(16'h0010 + 16'(i), 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
            step();
            chk("s_result", bus.out_result, 32'h10 + i);
            chk("s_in_ready", bus.in_ready, 1);
            chk("s_occ", bus.occupancy, 1);
        end
        idle();
        step();
        chk("s_drain_occ", bus.occupancy, 0);

        // flush while FULL with an offered bundle
        bus.out_ready = 1'b0;
        push(16'h00A1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        push(16'h00A2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        chk("fl_full", bus.occupancy, 2);
        chk("fl_stall2", bus.stall_cycles, 2);
        push(16'hBEEF, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        bus.flush = 1'b1;
        step();
        idle();
        chk("fl_occ", bus.occupancy, 0);
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_in_ready", bus.in_ready, 1);
        chk("fl_stall_kept", bus.stall_cycles, 3);
        step();
        chk("fl_no_beef", bus.out_valid, 0);

        // flush from ONE discards a same-cycle push
        push(16'h00C1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        chk("fl1_occ1", bus.occupancy, 1);
        push(16'hBEEF, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        bus.flush = 1'b1;
        step();
        idle();
        chk("fl1_occ", bus.occupancy, 0);
        chk("fl1_in_ready", bus.in_ready, 1);
        step();
        chk("fl1_no_beef", bus.out_valid, 0);

        // forwarding qualifiers
        bus.out_ready = 1'b1;
        push(16'h00FF, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        chk("fw_r0_valid", bus.out_valid, 1);
        chk("fw_r0_result", bus.out_result, 32'h00FF);
        chk("fw_r0_fwd", bus.fwd_valid, 0);
        push(16'h0055, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        chk("fw_norw_rd", bus.out_rd, 5);
        chk("fw_norw_fwd", bus.fwd_valid, 0);
        push(16'h0100, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        step();
        idle();
        chk("fw_load_fwd", bus.fwd_valid, 1);
        chk("fw_load_mr", bus.out_mem_read, 1);
        chk("fw_load_data", bus.fwd_data, 32'h0100);
        chk("fw_load_rd", bus.fwd_rd, 7);
        step();

        // stall counter saturation, then reset while FULL
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
        chk("sat_rst_stall", bus.stall_cycles, 0);
        bus.out_ready = 1'b0;
        push(16'h0077, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        idle();
        chk("sat_stall_k0", bus.stall_cycles, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("sat_stall", bus.stall_cycles, (k > 3) ? 3 : k);
        end
        push(16'h0078, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        idle();
        chk("rf_occ2", bus.occupancy, 2);
        chk("rf_in_ready0", bus.in_ready, 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rf_occ", bus.occupancy, 0);
        chk("rf_stall", bus.stall_cycles, 0);
        chk("rf_in_ready", bus.in_ready, 1);
        chk("rf_out_valid", bus.out_valid, 0);
        step();
        chk("rf_post_occ", bus.occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
